sram_rd_arbiter: RTL and testbench
==================================

// Module: sram_rd_arbiter
// PURPOSE
//  Two-master to one-slave AXI4-Lite read-channel arbiter in front of the simulated 64-bit SRAM.
//  Shares the single SRAM read port between IFU (master 0, instruction fetch) and LSU (master 1, loads).
//  One outstanding transaction in total; write channels bypass this block.
// PARAMETERS
//  ADDR_W    32  address width, all araddr ports
//  DATA_W    64  data width, all rdata ports
//  RR_EN     1   1: round-robin between masters on simultaneous requests; 0: fixed priority, m1 wins
// PORTS
//  aclk        in   1       clock, all logic on posedge
//  aresetn     in   1       asynchronous active-low reset
//  m0_araddr   in   ADDR_W  IFU read address
//  m0_arvalid  in   1       IFU address valid
//  m0_arready  out  1       IFU address accepted
//  m0_rdata    out  DATA_W  IFU read data
//  m0_rresp    out  2       IFU read response
//  m0_rvalid   out  1       IFU data valid
//  m0_rready   in   1       IFU data accept
//  m1_araddr   in   ADDR_W  LSU read address
//  m1_arvalid  in   1       LSU address valid
//  m1_arready  out  1       LSU address accepted
//  m1_rdata    out  DATA_W  LSU read data
//  m1_rresp    out  2       LSU read response
//  m1_rvalid   out  1       LSU data valid
//  m1_rready   in   1       LSU data accept
//  s_araddr    out  ADDR_W  SRAM read address (registered)
//  s_arvalid   out  1       SRAM address valid (registered)
//  s_arready   in   1       SRAM address accepted
//  s_rdata     in   DATA_W  SRAM read data
//  s_rresp     in   2       SRAM read response
//  s_rvalid    in   1       SRAM data valid
//  s_rready    out  1       SRAM data accept
// BEHAVIOUR
//  - FSM: IDLE -> ADDR -> DATA -> IDLE; state, grant (gnt), addr_q and rr pointer (last) are registers.
//  - IDLE: if any mX_arvalid, select winner; assert winner's mX_arready combinationally in the same cycle;
//    latch its araddr into addr_q, set gnt, go to ADDR.
//    Loser's arready = 0; it holds arvalid and waits.
//  - Selection: one requester wins outright. Both requesting: RR_EN=1 picks master != last; RR_EN=0 picks m1.
//    last updates at grant.
//  - ADDR: s_arvalid = 1, s_araddr = addr_q; on s_arready go to DATA. No mX_arready in ADDR/DATA.
//  - DATA: mGNT_rvalid = s_rvalid, mGNT_rdata/rresp = s_rdata/s_rresp, s_rready = mGNT_rready.
//    Non-granted master sees rvalid = 0, rdata = 0, rresp = 0.
//    On s_rvalid & s_rready go to IDLE; the next grant can occur in that IDLE cycle.
//  - Latency with the zero-wait SRAM: accept in cycle N, s_arvalid in N+1, mX_rvalid in N+2.
//    Back-to-back issue rate is 1 read per 3 cycles.
//  - rresp passes through unmodified; the arbiter generates no error responses.
//  - Reset (async, any state): state = IDLE, gnt = 0, last = 0 (m1 favoured first), addr_q = 0.
//    s_arvalid = 0, s_rready = 0, all mX_arready/rvalid = 0, rdata/rresp = 0.
//  - Reset mid-transaction: in-flight read is dropped, no response is delivered; masters re-issue after reset.
//  - mX_arvalid dropping before grant is tolerated (no grant issued).
// TESTING
//  - Reset: aresetn=0 mid-DATA -> all outputs 0 immediately; after release, a new m0 read completes normally.
//  - Single IFU read at 0x80000000, SRAM returns 0x00000413_00000297 -> m0_arready cycle N.
//    m0_rvalid and that rdata in N+2; m1 outputs stay 0.
//  - Simultaneous m0/m1 arvalid with RR_EN=1 from reset -> m1 served first.
//    m0 arready asserted 3 cycles later, in the IDLE cycle following the m1 handshake; then alternation.
//  - Same with RR_EN=0, both held valid for 4 reads -> m1 wins every arbitration; m0 never granted.
//  - Backpressure: m1_rready=0 for 5 cycles during DATA -> s_rready=0, m1_rvalid held with stable rdata.
//    m0 request stays unaccepted until the m1 handshake completes.
//  - SRAM s_rresp=2'b10 on m0 read -> m0_rresp=2'b10 with m0_rvalid; FSM returns to IDLE.

Source files
------------

// File: rtl/sram_rd_arbiter.sv
// Two-master AXI4-Lite read-channel arbiter sharing one SRAM read port.
// One read in flight at a time; the address phase to the SRAM is registered.
module sram_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pick_m1;
    logic              rready_sel;

    // last_q == 0 means m0 was served last (or nobody yet), so m1 goes first
    always_comb begin
        pick_m1 = m1_arvalid & (~m0_arvalid | ~RR_EN | ~last_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        rready_sel = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    gnt_d      = pick_m1;
                    last_d     = pick_m1;
                    addr_d     = pick_m1 ? m1_araddr : m0_araddr;
                    m0_arready = ~pick_m1;
                    m1_arready = pick_m1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (gnt_q) begin
                    m1_rvalid  = s_rvalid;
                    m1_rdata   = s_rdata;
                    m1_rresp   = s_rresp;
                    rready_sel = m1_rready;
                end else begin
                    m0_rvalid  = s_rvalid;
                    m0_rdata   = s_rdata;
                    m0_rresp   = s_rresp;
                    rready_sel = m0_rready;
                end
                if (s_rvalid && rready_sel) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_arvalid = (state_q == ADDR);
    assign s_araddr  = addr_q;
    assign s_rready  = rready_sel;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Scoreboard bench for sram_rd_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Each instance sits in front of a zero-wait SRAM model.
module tb_sram_rd_arbiter;

    typedef struct packed {
        logic        m;
        logic [63:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] m0_araddr[2], m1_araddr[2], s_araddr[2], pend_addr[2];
    logic        m0_arvalid[2], m0_arready[2], m0_rvalid[2], m0_rready[2];
    logic        m1_arvalid[2], m1_arready[2], m1_rvalid[2], m1_rready[2];
    logic        s_arvalid[2], s_arready[2], s_rvalid[2], s_rready[2];
    logic        pend[2];
    logic [63:0] m0_rdata[2], m1_rdata[2], s_rdata[2];
    logic [1:0]  m0_rresp[2], m1_rresp[2], s_rresp[2];

    exp_t        sb0[$];
    exp_t        sb1[$];

    int r1a, r1b, r0a, r0b;
    int fp_acc[4];
    int fp_m0;
    bit fp_m0_done;
    int b1, b0, hs;
    int e0, e1, x0, x1, t1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sram_rd_arbiter #(
            .ADDR_W(32),
            .DATA_W(64),
            .RR_EN (k == 0)
        ) u_dut (
            .aclk      (clk),
            .aresetn   (rst_n),
            .m0_araddr (m0_araddr[k]),
            .m0_arvalid(m0_arvalid[k]),
            .m0_arready(m0_arready[k]),
            .m0_rdata  (m0_rdata[k]),
            .m0_rresp  (m0_rresp[k]),
            .m0_rvalid (m0_rvalid[k]),
            .m0_rready (m0_rready[k]),
            .m1_araddr (m1_araddr[k]),
            .m1_arvalid(m1_arvalid[k]),
            .m1_arready(m1_arready[k]),
            .m1_rdata  (m1_rdata[k]),
            .m1_rresp  (m1_rresp[k]),
            .m1_rvalid (m1_rvalid[k]),
            .m1_rready (m1_rready[k]),
            .s_araddr  (s_araddr[k]),
            .s_arvalid (s_arvalid[k]),
            .s_arready (s_arready[k]),
            .s_rdata   (s_rdata[k]),
            .s_rresp   (s_rresp[k]),
            .s_rvalid  (s_rvalid[k]),
            .s_rready  (s_rready[k])
        );
    end

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h00000413_00000297;
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return (a[31:28] == 4'hE) ? 2'b10 : 2'b00;
    endfunction

    // zero-wait SRAM: address taken at the edge, data valid the next cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                pend[k]      <= 1'b0;
                pend_addr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (s_arvalid[k] && s_arready[k]) begin
                    pend[k]      <= 1'b1;
                    pend_addr[k] <= s_araddr[k];
                end else if (s_rvalid[k] && s_rready[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            s_arready[k] = 1'b1;
            s_rvalid[k]  = pend[k];
            s_rdata[k]   = pend[k] ? mem_rd(pend_addr[k]) : 64'h0;
            s_rresp[k]   = pend[k] ? mem_resp(pend_addr[k]) : 2'b00;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int m, input logic [31:0] a);
        exp_t e;
        e.m = m[0];
        e.d = mem_rd(a);
        e.r = mem_resp(a);
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic pop_chk(input int k, input int m, input logic [63:0] d,
                           input logic [1:0] r);
        exp_t e;
        int   sz;
        sz = (k == 0) ? sb0.size() : sb1.size();
        if (sz == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: dut %0d m%0d got data %0h, expected no response",
                     k, m, d);
            return;
        end
        if (k == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        chk("resp_master", 64'(m), 64'(e.m));
        chk("resp_rdata", d, e.d);
        chk("resp_rresp", 64'(r), 64'(e.r));
    endtask

    // monitor: every completed R handshake is matched against the scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m0_rvalid[k] && m0_rready[k]) begin
                pop_chk(k, 0, m0_rdata[k], m0_rresp[k]);
                chk("m1_quiet_rvalid", 64'(m1_rvalid[k]), 64'h0);
                chk("m1_quiet_rdata", m1_rdata[k], 64'h0);
            end
            if (m1_rvalid[k] && m1_rready[k]) begin
                pop_chk(k, 1, m1_rdata[k], m1_rresp[k]);
                chk("m0_quiet_rvalid", 64'(m0_rvalid[k]), 64'h0);
                chk("m0_quiet_rdata", m0_rdata[k], 64'h0);
            end
        end
    end

    task automatic set_ar(input int k, input int m, input logic v,
                          input logic [31:0] a);
        if (m == 0) begin
            m0_arvalid[k] = v;
            m0_araddr[k]  = a;
        end else begin
            m1_arvalid[k] = v;
            m1_araddr[k]  = a;
        end
    endtask

    function automatic logic get_arready(input int k, input int m);
        return (m == 0) ? m0_arready[k] : m1_arready[k];
    endfunction

    task automatic issue(input int k, input int m, input logic [31:0] a,
                         output int acc);
        int n;
        bit ok;
        n   = 0;
        ok  = 1'b0;
        acc = -1;
        set_ar(k, m, 1'b1, a);
        while (!ok && n < 40) begin
            @(negedge clk);
            if (get_arready(k, m)) begin
                ok  = 1'b1;
                acc = cyc;
                push(k, m, a);
            end
            n++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ar_timeout: dut %0d m%0d addr %0h got no arready, expected one within 40 cycles",
                     k, m, a);
        end
        @(posedge clk);
        #1;
        set_ar(k, m, 1'b0, 32'h0);
    endtask

    task automatic outputs_zero(input int k);
        chk("rst_m0_arready", 64'(m0_arready[k]), 64'h0);
        chk("rst_m1_arready", 64'(m1_arready[k]), 64'h0);
        chk("rst_m0_rvalid", 64'(m0_rvalid[k]), 64'h0);
        chk("rst_m1_rvalid", 64'(m1_rvalid[k]), 64'h0);
        chk("rst_m0_rdata", m0_rdata[k], 64'h0);
        chk("rst_m1_rdata", m1_rdata[k], 64'h0);
        chk("rst_rresp", 64'({m0_rresp[k], m1_rresp[k]}), 64'h0);
        chk("rst_s_arvalid", 64'(s_arvalid[k]), 64'h0);
        chk("rst_s_rready", 64'(s_rready[k]), 64'h0);
        chk("rst_s_araddr", 64'(s_araddr[k]), 64'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m0_arvalid[k] = 1'b0;
            m1_arvalid[k] = 1'b0;
            m0_araddr[k]  = '0;
            m1_araddr[k]  = '0;
            m0_rready[k]  = 1'b1;
            m1_rready[k]  = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        outputs_zero(0);
        outputs_zero(1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single IFU read: accept N, s_arvalid N+1, rvalid N+2
        issue(0, 0, 32'h8000_0000, t1);
        @(negedge clk);
        chk("t1_addr_cycle", 64'(cyc), 64'(t1 + 1));
        chk("t1_s_arvalid", 64'(s_arvalid[0]), 64'h1);
        chk("t1_s_araddr", 64'(s_araddr[0]), 64'h8000_0000);
        @(negedge clk);
        chk("t1_m0_rvalid", 64'(m0_rvalid[0]), 64'h1);
        chk("t1_m0_rdata", m0_rdata[0], 64'h00000413_00000297);
        chk("t1_m1_rvalid", 64'(m1_rvalid[0]), 64'h0);
        chk("t1_m1_rdata", m1_rdata[0], 64'h0);
        idle(3);

        // round-robin from reset: m1, m0, m1, m0 every 3 cycles
        do_reset();
        fork
            begin
                issue(0, 1, 32'h1000_0000, r1a);
                issue(0, 1, 32'h1000_0008, r1b);
            end
            begin
                issue(0, 0, 32'h2000_0000, r0a);
                issue(0, 0, 32'h2000_0008, r0b);
            end
        join
        chk("rr_m0_first_grant", 64'(r0a), 64'(r1a + 3));
        chk("rr_m1_second_grant", 64'(r1b), 64'(r0a + 3));
        chk("rr_m0_second_grant", 64'(r0b), 64'(r1b + 3));
        idle(4);

        // fixed priority: m1 wins all four arbitrations
        fp_m0      = -1;
        fp_m0_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(1, 1, 32'h3000_0000 + 32'(i * 8), fp_acc[i]);
                end
                chk("fp_m0_not_granted", 64'(fp_m0_done), 64'h0);
            end
            begin
                issue(1, 0, 32'h4000_0000, fp_m0);
                fp_m0_done = 1'b1;
            end
        join
        for (int i = 1; i < 4; i++) begin
            chk("fp_m1_spacing", 64'(fp_acc[i]), 64'(fp_acc[i-1] + 3));
        end
        chk("fp_m0_after_m1", 64'(fp_m0), 64'(fp_acc[3] + 3));
        idle(4);

        // backpressure on m1 while m0 waits
        m1_rready[0] = 1'b0;
        issue(0, 1, 32'h5000_0000, b1);
        fork
            issue(0, 0, 32'h6000_0000, b0);
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_m1_rvalid", 64'(m1_rvalid[0]), 64'h1);
                    chk("bp_m1_rdata", m1_rdata[0], mem_rd(32'h5000_0000));
                    chk("bp_s_rready", 64'(s_rready[0]), 64'h0);
                    chk("bp_m0_arready", 64'(m0_arready[0]), 64'h0);
                end
                @(posedge clk);
                #1;
                m1_rready[0] = 1'b1;
                hs = cyc;
            end
        join
        chk("bp_m0_after_hs", 64'(b0), 64'(hs + 1));
        idle(4);

        // SLVERR passes through, FSM back in IDLE right after
        issue(0, 0, 32'hE000_0040, e0);
        @(negedge clk);
        @(negedge clk);
        chk("err_m0_rvalid", 64'(m0_rvalid[0]), 64'h1);
        chk("err_m0_rresp", 64'(m0_rresp[0]), 64'h2);
        @(posedge clk);
        #1;
        issue(0, 0, 32'h7000_0000, e1);
        chk("err_back_to_idle", 64'(e1), 64'(e0 + 3));
        idle(4);

        // reset while m0 is stalled in DATA: response dropped
        m0_rready[0] = 1'b0;
        issue(0, 0, 32'h8000_0100, x0);
        @(posedge clk);
        #1;
        chk("rst_pre_m0_rvalid", 64'(m0_rvalid[0]), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        outputs_zero(0);
        sb0.delete();
        m0_rready[0] = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(0, 0, 32'h8000_0000, x1);
        idle(4);

        chk("sb0_drained", 64'(sb0.size()), 64'h0);
        chk("sb1_drained", 64'(sb1.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
